// File: rtl/acia_rx_if.sv
// Bus bundle between the 6551 receive datapath and its register/status block.
// Line-side controls and the CPU read strobe come in; received word and status go out.
interface acia_rx_if;
    // Handshake: rdrf is the "word valid" flag. It stays high until the CPU
    // accepts the word with a single-cycle rd_ack pulse. rd_ack while rdrf=0
    // is harmless. rdrf drops on the cycle after an rd_ack with no word completing.
    logic       baud16_tick;
    logic       rx_en;
    logic       rxd;
    logic [1:0] wl;
    logic       par_en;
    logic [1:0] par_mode;
    logic       rd_ack;
    logic [7:0] rx_data;
    logic       rdrf;
    logic       overrun;
    logic       framing_err;
    logic       parity_err;
    logic       rx_busy;
    logic [2:0] state_dbg;

    modport master (
        output baud16_tick, rx_en, rxd, wl, par_en, par_mode, rd_ack,
        input  rx_data, rdrf, overrun, framing_err, parity_err, rx_busy, state_dbg
    );

    modport slave (
        input  baud16_tick, rx_en, rxd, wl, par_en, par_mode, rd_ack,
        output rx_data, rdrf, overrun, framing_err, parity_err, rx_busy, state_dbg
    );
endinterface

// File: rtl/acia_rx.sv
// 6551 ACIA receiver: 16x-oversampled UART deserialiser producing the
// receive data register and its RDRF/overrun/framing/parity status bits.
module acia_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int MID_SAMPLE  = 7
) (
    input  logic       xtli,
    input  logic       reset,
    acia_rx_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;

    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_q;
    logic [1:0] wl_q;
    logic       par_en_q;
    logic [1:0] par_mode_q;
    logic       par_err_q;

    logic [7:0] rx_data_q;
    logic       rdrf_q;
    logic       overrun_q;
    logic       framing_q;
    logic       parity_q;

    logic mid_tick;
    logic bit_tick;
    logic last_bit;
    logic frame_go;
    logic complete;
    logic par_bad;

    // Line is idle-high, so the synchroniser resets to 1 to avoid a phantom start bit.
    always_ff @(posedge xtli or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rxd};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // State register
    always_ff @(posedge xtli or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (!rxd_s) state_next = START;
            START:      if (mid_tick) state_next = rxd_s ? IDLE : DATA;
            DATA:       if (bit_tick && last_bit) state_next = par_en_q ? PARITY : STOP;
            PARITY:     if (bit_tick) state_next = STOP;
            STOP:       if (bit_tick) state_next = rxd_s ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (rxd_s) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
        if (!bus.rx_en) begin
            state_next = IDLE;
        end
    end

    // Output / strobe logic
    always_comb begin
        mid_tick      = bus.baud16_tick && (tick_cnt == 4'(MID_SAMPLE));
        bit_tick      = bus.baud16_tick && (tick_cnt == 4'd15);
        frame_go      = (state == START) && mid_tick && !rxd_s && bus.rx_en;
        complete      = (state == STOP) && bit_tick && bus.rx_en;
        bus.rx_busy   = (state != IDLE);
        bus.state_dbg = state;
    end

    // Word length 8/7/6/5 maps to last bit index 7/6/5/4.
    assign last_bit = (bit_cnt == (3'd7 - {1'b0, wl_q}));

    always_comb begin
        par_bad = 1'b0;
        case (par_mode_q)
            2'b00: par_bad = ((^shift_q) ^ rxd_s) != 1'b1;
            2'b01: par_bad = ((^shift_q) ^ rxd_s) != 1'b0;
            2'b10: par_bad = !rxd_s;
            2'b11: par_bad = rxd_s;
            default: par_bad = 1'b0;
        endcase
    end

    // Tick counter restarts at every state entry so each state times its own samples.
    always_ff @(posedge xtli or posedge reset) begin
        if (reset) begin
            tick_cnt <= 4'd0;
        end else if (state_next != state || state == IDLE) begin
            tick_cnt <= 4'd0;
        end else if (bus.baud16_tick) begin
            tick_cnt <= tick_cnt + 4'd1;
        end
    end

    // Frame datapath; format is captured on START->DATA so mid-frame writes cannot disturb it.
    always_ff @(posedge xtli or posedge reset) begin
        if (reset) begin
            wl_q       <= 2'd0;
            par_en_q   <= 1'b0;
            par_mode_q <= 2'd0;
            shift_q    <= 8'd0;
            bit_cnt    <= 3'd0;
            par_err_q  <= 1'b0;
        end else if (frame_go) begin
            wl_q       <= bus.wl;
            par_en_q   <= bus.par_en;
            par_mode_q <= bus.par_mode;
            shift_q    <= 8'd0;
            bit_cnt    <= 3'd0;
            par_err_q  <= 1'b0;
        end else if (state == DATA && bit_tick) begin
            shift_q[bit_cnt] <= rxd_s;
            bit_cnt          <= bit_cnt + 3'd1;
        end else if (state == PARITY && bit_tick) begin
            par_err_q <= par_bad;
        end
    end

    // Receive data register and status
    always_ff @(posedge xtli or posedge reset) begin
        if (reset) begin
            rx_data_q <= 8'd0;
            rdrf_q    <= 1'b0;
            overrun_q <= 1'b0;
            framing_q <= 1'b0;
            parity_q  <= 1'b0;
        end else if (complete) begin
            if (!rdrf_q || bus.rd_ack) begin
                rx_data_q <= shift_q;
                framing_q <= !rxd_s;
                parity_q  <= par_err_q;
                rdrf_q    <= 1'b1;
                if (bus.rd_ack) begin
                    overrun_q <= 1'b0;
                end
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (bus.rd_ack) begin
            rdrf_q    <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rdrf        = rdrf_q;
    assign bus.overrun     = overrun_q;
    assign bus.framing_err = framing_q;
    assign bus.parity_err  = parity_q;

endmodule

// File: tb/tb_acia_rx.sv
// Bench for acia_rx: table of frame formats plus hand-written sequences for
// overrun, break, false start, reset mid-frame and read/complete collision.
module tb_acia_rx;

    localparam int CLKS_PER_TICK = 4;
    localparam int CLKS_PER_BIT  = 16 * CLKS_PER_TICK;

    logic xtli  = 1'b0;
    logic reset = 1'b1;

    acia_rx_if bus();

    acia_rx #(.SYNC_STAGES(2), .MID_SAMPLE(7)) dut (
        .xtli  (xtli),
        .reset (reset),
        .bus   (bus)
    );

    always #5 xtli = ~xtli;

    typedef struct {
        logic [7:0] data;
        logic [1:0] wl;
        logic       par_en;
        logic [1:0] par_mode;
        logic       par_bit;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t       vecs[8];
    logic [9:0] exp_q[$];
    logic [9:0] sb_e;
    logic       rdrf_prev = 1'b0;
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         tick_div  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Clock/reset-side stimulus: baud tick every CLKS_PER_TICK cycles
    initial begin
        bus.baud16_tick = 1'b0;
        forever begin
            @(negedge xtli);
            tick_div = (tick_div + 1) % CLKS_PER_TICK;
            bus.baud16_tick = (tick_div == 0);
        end
    end

    // Scoreboard: each rising RDRF pops one expected {data, fe, pe}
    initial begin
        forever begin
            @(negedge xtli);
            #2;
            if (bus.rdrf && !rdrf_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(bus.rx_data), 32'hFFFF);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_data", 32'(bus.rx_data), 32'(sb_e[9:2]));
                    chk("sb_fe", 32'(bus.framing_err), 32'(sb_e[1]));
                    chk("sb_pe", 32'(bus.parity_err), 32'(sb_e[0]));
                end
            end
            rdrf_prev = bus.rdrf;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge xtli);
    endtask

    task automatic send_bit(input logic b);
        @(negedge xtli);
        bus.rxd = b;
        wait_clks(CLKS_PER_BIT - 1);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (par_en) send_bit(par_bit);
        send_bit(stop_bit);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge xtli);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_ack();
        @(negedge xtli);
        bus.rd_ack = 1'b1;
        @(negedge xtli);
        bus.rd_ack = 1'b0;
        #1;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        bus.wl       = v.wl;
        bus.par_en   = v.par_en;
        bus.par_mode = v.par_mode;
        exp_q.push_back({v.exp_data, v.exp_fe, v.exp_pe});
        send_frame(v.data, 8 - int'(v.wl), v.par_en, v.par_bit, v.stop_bit);
        bus.rxd = 1'b1;
        wait_drain(100);
        chk({tag, "_ovr"}, 32'(bus.overrun), 32'd0);
        pulse_ack();
        chk({tag, "_rdrf_clr"}, 32'(bus.rdrf), 32'd0);
        chk({tag, "_data_hold"}, 32'(bus.rx_data), 32'(v.exp_data));
    endtask

    // Raise rd_ack on exactly the tick that samples the stop bit
    task automatic ack_at_completion();
        int  n    = 0;
        logic hit = 1'b0;
        for (int i = 0; i < 20 * CLKS_PER_BIT && !hit; i++) begin
            @(negedge xtli);
            #1;
            if (bus.state_dbg == 3'd4 && bus.baud16_tick) begin
                n++;
                if (n == 16) begin
                    bus.rd_ack = 1'b1;
                    @(negedge xtli);
                    bus.rd_ack = 1'b0;
                    hit = 1'b1;
                end
            end
        end
        chk("ack_sync_found", 32'(hit), 32'd1);
    endtask

    initial begin
        vec_t v;
        logic [7:0] d;
        logic       bad;

        bus.rxd = 1'b1; bus.rx_en = 1'b1; bus.wl = 2'd0;
        bus.par_en = 1'b0; bus.par_mode = 2'd0; bus.rd_ack = 1'b0;

        vecs[0] = '{8'hA5, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h13, 2'd3, 1'b1, 2'b01, 1'b0, 1'b1, 8'h13, 1'b0, 1'b1};
        vecs[2] = '{8'h13, 2'd3, 1'b1, 2'b01, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0};
        vecs[3] = '{8'h5A, 2'd1, 1'b1, 2'b00, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[4] = '{8'hEB, 2'd2, 1'b1, 2'b10, 1'b0, 1'b1, 8'h2B, 1'b0, 1'b1};
        vecs[5] = '{8'hC3, 2'd0, 1'b1, 2'b11, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 2'd0, 1'b1, 2'b01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[7] = '{8'h7F, 2'd1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0};

        wait_clks(5);
        #1;
        chk("rst_rdrf", 32'(bus.rdrf), 32'd0);
        chk("rst_data", 32'(bus.rx_data), 32'd0);
        chk("rst_status", 32'({bus.overrun, bus.framing_err, bus.parity_err}), 32'd0);
        chk("rst_busy", 32'(bus.rx_busy), 32'd0);
        @(negedge xtli);
        reset = 1'b0;
        wait_clks(10);

        for (int i = 0; i < 8; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Random 8E1 frames with occasional corrupted parity
        for (int i = 0; i < 4; i++) begin
            d   = 8'($urandom_range(0, 255));
            bad = 1'($urandom_range(0, 1));
            v   = '{d, 2'd0, 1'b1, 2'b01, (^d) ^ bad, 1'b1, d, 1'b0, bad};
            run_frame(v, $sformatf("rnd%0d", i));
        end

        // Overrun: second word discarded, first word held
        bus.wl = 2'd0; bus.par_en = 1'b0;
        exp_q.push_back({8'h3C, 1'b0, 1'b0});
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        wait_drain(100);
        send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1);
        wait_clks(10);
        #1;
        chk("ovr_data", 32'(bus.rx_data), 32'h3C);
        chk("ovr_flag", 32'(bus.overrun), 32'd1);
        chk("ovr_rdrf", 32'(bus.rdrf), 32'd1);
        pulse_ack();
        chk("ovr_ack_rdrf", 32'(bus.rdrf), 32'd0);
        chk("ovr_ack_flag", 32'(bus.overrun), 32'd0);

        // Break: stop bit 0 and line held low for 40 bit times
        exp_q.push_back({8'h00, 1'b1, 1'b0});
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0);
        wait_clks(40 * CLKS_PER_BIT);
        #1;
        chk("brk_busy_low", 32'(bus.rx_busy), 32'd1);
        wait_drain(10);
        bus.rxd = 1'b1;
        wait_clks(10);
        #1;
        chk("brk_busy_rel", 32'(bus.rx_busy), 32'd0);
        chk("brk_fe", 32'(bus.framing_err), 32'd1);
        chk("brk_data", 32'(bus.rx_data), 32'd0);
        wait_clks(4 * CLKS_PER_BIT);
        pulse_ack();

        // False start: 4-tick low glitch
        @(negedge xtli);
        bus.rxd = 1'b0;
        wait_clks(4 * CLKS_PER_TICK);
        bus.rxd = 1'b1;
        wait_clks(100);
        #1;
        chk("fs_rdrf", 32'(bus.rdrf), 32'd0);
        chk("fs_busy", 32'(bus.rx_busy), 32'd0);

        // RX_EN drop mid-frame discards the partial word
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus.rx_en = 1'b0;
        wait_clks(3);
        #1;
        chk("rxen_busy", 32'(bus.rx_busy), 32'd0);
        bus.rxd = 1'b1;
        wait_clks(10 * CLKS_PER_BIT);
        bus.rx_en = 1'b1;
        wait_clks(10);
        chk("rxen_rdrf", 32'(bus.rdrf), 32'd0);

        // Reset during data bit 3 while a word is held
        exp_q.push_back({8'h81, 1'b0, 1'b0});
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
        wait_drain(100);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        @(negedge xtli);
        bus.rxd = 1'b0;
        wait_clks(20);
        reset = 1'b1;
        #1;
        chk("mrst_rdrf", 32'(bus.rdrf), 32'd0);
        chk("mrst_data", 32'(bus.rx_data), 32'd0);
        chk("mrst_busy", 32'(bus.rx_busy), 32'd0);
        bus.rxd = 1'b1;
        wait_clks(5);
        reset = 1'b0;
        wait_clks(20);
        exp_q.push_back({8'h55, 1'b0, 1'b0});
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        wait_drain(100);
        pulse_ack();

        // RD_ACK coincident with completion while RDRF=1 and OVERRUN=1
        exp_q.push_back({8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
        wait_drain(100);
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1);
        wait_clks(5);
        chk("col_pre_ovr", 32'(bus.overrun), 32'd1);
        fork
            send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
            ack_at_completion();
        join
        wait_clks(2);
        #1;
        chk("col_data", 32'(bus.rx_data), 32'h22);
        chk("col_rdrf", 32'(bus.rdrf), 32'd1);
        chk("col_ovr", 32'(bus.overrun), 32'd0);
        pulse_ack();
        wait_clks(20);
        chk("final_q", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/acia_rx.md
Name: acia_rx

Overview:
- Receive datapath of the 6551 ACIA: 16x-oversampled asynchronous receiver.
- Deserialises RXD into the receive data register.
- Produces the RDRF, overrun, framing and parity status bits consumed by the ACIA register/status interface.
- Sits upstream of the register file: the bus-side read of the data register returns RX_DATA and pulses RD_ACK.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising RXD into the XTLI domain (min 2).
- MID_SAMPLE, 7, tick index (0..15) within a bit at which the bit is sampled.

Ports:
- XTLI  input  1  receiver clock; all state on rising edge
- RESET  input  1  asynchronous reset, active-high
- BAUD16_TICK  input  1  one-XTLI-cycle enable at 16x the selected baud rate
- RX_EN  input  1  receiver enable (DTR asserted); 0 forces IDLE
- RXD  input  1  serial input, idle high, asynchronous
- WL  input  2  word length: 00=8, 01=7, 10=6, 11=5 data bits
- PAR_EN  input  1  parity bit expected after data
- PAR_MODE  input  2  00 odd, 01 even, 10 mark (1), 11 space (0)
- RD_ACK  input  1  single-cycle pulse: CPU read of the data register
- RX_DATA  output  8  received word, LSB-aligned, unused upper bits 0
- RDRF  output  1  receive data register full
- OVERRUN  output  1  a word arrived while RDRF=1
- FRAMING_ERR  output  1  stop bit sampled 0 for the held word
- PARITY_ERR  output  1  parity mismatch for the held word
- RX_BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchroniser flops set to 1, counters cleared.
- RXD passes through SYNC_STAGES flops. All references to RXD below mean the synchronised value.
- Tick counter (4 bits) advances only on BAUD16_TICK and wraps 15->0. It is cleared on every state entry.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE -> START on the first XTLI cycle where RXD=0 and RX_EN=1.
- START: at tick MID_SAMPLE, if RXD=1 treat as a false start and return to IDLE. Otherwise clear the tick counter and go to DATA.
- Each subsequent bit is sampled at tick 15, i.e. 16 ticks after the previous sample.
- DATA: shift bits in LSB first; bit count = 8/7/6/5 from WL. After the last bit go to PARITY if PAR_EN, else STOP.
- PARITY: sample the bit and compare against the expected value.
  - Odd: XOR(data bits) XOR parity bit must equal 1.
  - Even: the same XOR must equal 0.
  - Mark: the bit must be 1.
  - Space: the bit must be 0.
- STOP: sample the stop bit (only the first stop bit is checked), then complete the word.
  - If the stop bit is 1, go to IDLE.
  - If the stop bit is 0, go to BREAK_WAIT, which returns to IDLE once RXD=1.
- WL and PAR_* are latched on START->DATA. Changes mid-frame do not affect the frame in flight.
- Word completion when RDRF=0, or when RDRF=1 with RD_ACK in the same cycle:
  - RX_DATA, FRAMING_ERR and PARITY_ERR are loaded; RDRF=1.
  - OVERRUN is unchanged, except a concurrent RD_ACK clears it.
- Word completion when RDRF=1 and no RD_ACK:
  - OVERRUN=1; the new word is discarded.
  - RX_DATA, FRAMING_ERR and PARITY_ERR keep their values.
- RD_ACK with no completion: clears RDRF and OVERRUN next cycle. RX_DATA and the error bits hold until the next load.
- RX_EN=0: FSM goes to IDLE immediately and the partial word is discarded. Status outputs are retained.
- Status latency: RDRF rises one XTLI cycle after the BAUD16_TICK that samples the stop bit.
- RESET asserted mid-frame: all state clears immediately. After release the receiver waits for a fresh falling edge. A line held low at release is seen as a start.

Test Plan:
- 8N1, 0x A5 sent (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) -> RX_DATA=0xA5, RDRF=1, FE=0, PE=0. RD_ACK pulse -> RDRF=0, RX_DATA still 0xA5.
- WL=11 (5 bits), even parity, data 0x13 with parity bit 0 -> RX_DATA=0x13, PE=1. Repeat with parity bit 1 -> PE=0.
- 8N1, 0x3C then 0x7E, no RD_ACK between -> RX_DATA=0x3C, OVERRUN=1. RD_ACK -> RDRF=0, OVERRUN=0.
- 8N1, stop bit driven 0 and RXD held low 40 bit times -> FE=1, RX_DATA=0x00, RX_BUSY high until RXD returns high, no second word.
- 0-pulse of 4 ticks on RXD -> false start, IDLE, RDRF stays 0. Also: RESET asserted at data bit 3 -> all outputs 0, next clean 0x55 frame received correctly.
- RD_ACK coincident with completion of a second word (RDRF=1) -> new word loaded, RDRF=1, OVERRUN=0.
